// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial WIDTH-bit subtractor, diff = a - b - bin.
// One full-subtractor stage processes one bit per clock, LSB first.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  request, accepted only while busy=0
//   a, b   minuend / subtrahend, captured on the accepting edge
//   bin    borrow-in, captured on the accepting edge
//   busy   high in SHIFT and DONE
//   done   one-cycle pulse when diff/bout carry a new result
//   diff   registered result (held between operations)
//   bout   registered borrow-out of the MSB
//   ovf    (only with SERIAL_SUBTRACTOR_OVF_EN) signed overflow, registered
//
// Optional feature macro: SERIAL_SUBTRACTOR_OVF_EN

// Single-bit full subtractor stage.
module serial_subtractor_fs (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);
  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);
endmodule

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] sa, sb, rs, rs_nx;
  logic             br, br_nx, d;
  logic [CW-1:0]    cnt;
  logic             last;

  serial_subtractor_fs u_fs (
    .x  (sa[0]),
    .y  (sb[0]),
    .bi (br),
    .d  (d),
    .bo (br_nx)
  );

  // Result bits enter at the MSB so after WIDTH shifts rs is aligned.
  generate
    if (WIDTH == 1) begin : g_rs1
      assign rs_nx = d;
    end else begin : g_rsn
      assign rs_nx = {d, rs[WIDTH-1:1]};
    end
  endgenerate

  assign last = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE:  if (start) state_nx = SHIFT;
      SHIFT: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE:  begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa   <= '0;
      sb   <= '0;
      rs   <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      diff <= '0;
      bout <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      ovf  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          sa  <= a;
          sb  <= b;
          br  <= bin;
          cnt <= '0;
        end
        SHIFT: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          br  <= br_nx;
          rs  <= rs_nx;
          cnt <= cnt + CW'(1);
          // Outputs update only here, so partial results never show.
          if (last) begin
            diff <= rs_nx;
            bout <= br_nx;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            // br is the borrow into the MSB on this edge.
            ovf  <= br ^ br_nx;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  typedef struct {
    logic [7:0] d;
    logic       bo;
    logic       ov;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start8 = 1'b0, bin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, bout8, ovf8;
  logic [7:0] diff8;
  logic       start1 = 1'b0, bin1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       busy1, done1, bout1, ovf1;
  logic [0:0] diff1;

  int   total = 0;
  int   bad = 0;
  exp_t q8[$];
  exp_t q1[$];

  always #5 clk = ~clk;

`ifndef SERIAL_SUBTRACTOR_OVF_EN
  assign ovf8 = 1'b0;
  assign ovf1 = 1'b0;
`endif

  serial_subtractor #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_subtractor #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .bin(bin1),
    .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    , .ovf(ovf1)
`endif
  );

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: pops an expected result on every done pulse.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (done8) begin
        if (q8.size() == 0) chk("w8 unexpected done", 1, 0);
        else begin
          e = q8.pop_front();
          chk("w8 diff", diff8, e.d);
          chk("w8 bout", bout8, e.bo);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
          chk("w8 ovf", ovf8, e.ov);
`endif
        end
      end
      if (done1) begin
        if (q1.size() == 0) chk("w1 unexpected done", 1, 0);
        else begin
          e = q1.pop_front();
          chk("w1 diff", diff1, e.d[0]);
          chk("w1 bout", bout1, e.bo);
        end
      end
    end
  endtask

  // Issue one WIDTH=8 op; check done latency, busy length and optional hold.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                      input logic [7:0] ed, input logic eb, input logic eo,
                      input logic hold, input logic [7:0] hv);
    int n, bc, dat;
    @(negedge clk);
    a8 = a; b8 = b; bin8 = bi; start8 = 1'b1;
    q8.push_back('{ed, eb, eo});
    @(posedge clk); #1;
    start8 = 1'b0;
    a8 = ~a; b8 = ~b; bin8 = ~bi;   // inputs after capture must not matter
    n = 0; bc = 0; dat = -1;
    while (busy8 && n < 40) begin
      bc++;
      if (done8 && dat < 0) dat = n;
      if (hold && !done8) chk("w8 diff hold", diff8, hv);
      @(posedge clk); #1;
      n++;
    end
    chk("w8 done latency", dat, 8);
    chk("w8 busy cycles", bc, 9);
  endtask

  task automatic run1(input int i, input logic ed, input logic eb);
    int n, dat;
    @(negedge clk);
    a1 = i[2]; b1 = i[1]; bin1 = i[0]; start1 = 1'b1;
    q1.push_back('{{7'd0, ed}, eb, 1'b0});
    @(posedge clk); #1;
    start1 = 1'b0;
    n = 0; dat = -1;
    while (busy1 && n < 10) begin
      if (done1 && dat < 0) dat = n;
      @(posedge clk); #1;
      n++;
    end
    chk("w1 done latency", dat, 1);
  endtask

  logic [1:0] exp1 [8] = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};

  initial begin
    int n;
    fork monitor(); join_none

    #12;
    chk("reset busy", busy8, 0);
    chk("reset done", done8, 0);
    chk("reset diff", diff8, 0);
    chk("reset bout", bout8, 0);
    @(negedge clk); rst_n = 1'b1;

    // Basic ops and result hold through a following op.
    run8(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 8'h00);
    run8(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0, 8'h00);
    run8(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 8'hFE);
    run8(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0, 8'h00);
    run8(8'h7F, 8'h01, 1'b0, 8'h7E, 1'b0, 1'b0, 1'b0, 8'h00);

    // Start mid-SHIFT and during DONE must be ignored; held start retriggers.
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
    q8.push_back('{8'h0F, 1'b0, 1'b0});
    @(posedge clk); #1; start8 = 1'b0;
    repeat (3) @(posedge clk); #1;
    a8 = 8'hFF; b8 = 8'h00; start8 = 1'b1;
    @(posedge clk); #1; start8 = 1'b0;
    chk("busy after mid-shift start", busy8, 1);
    n = 0;
    while (!done8 && n < 20) begin @(negedge clk); n++; end
    chk("first op done seen", done8, 1);
    a8 = 8'h20; b8 = 8'h10; bin8 = 1'b0; start8 = 1'b1;
    q8.push_back('{8'h10, 1'b0, 1'b0});
    @(posedge clk); #1;
    chk("idle after done w/ start", busy8, 0);
    @(posedge clk); #1;
    chk("retrigger on first idle edge", busy8, 1);
    start8 = 1'b0;
    n = 0;
    while (busy8 && n < 20) begin @(posedge clk); #1; n++; end
    chk("second op finished", busy8, 0);

    // Asynchronous reset mid-operation.
    @(negedge clk);
    a8 = 8'h55; b8 = 8'h22; bin8 = 1'b0; start8 = 1'b1;
    q8.push_back('{8'h33, 1'b0, 1'b0});
    @(posedge clk); #1; start8 = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst busy", busy8, 0);
    chk("async rst done", done8, 0);
    chk("async rst diff", diff8, 0);
    chk("async rst bout", bout8, 0);
    chk("async rst ovf", ovf8, 0);
    void'(q8.pop_back());
    @(negedge clk); rst_n = 1'b1;
    run8(8'h55, 8'h22, 1'b0, 8'h33, 1'b0, 1'b0, 1'b0, 8'h00);

    // WIDTH=1 exhaustive truth table.
    for (int i = 0; i < 8; i++) begin
      logic [1:0] e;
      e = exp1[i];
      run1(i, e[1], e[0]);
    end

    repeat (3) @(negedge clk);
    chk("w8 queue drained", q8.size(), 0);
    chk("w1 queue drained", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1);
  end

endmodule
